syst_feed_ctrl: RTL

- Sequencer that feeds the systolic array and result FIFO path (array wrapper plus result FIFO).
- Per job, accepts N input vectors from an upstream valid/ready source and issues them to the array input.
- Generates the array-level valid plus the four skewed per-row valids.
- Tracks result-FIFO occupancy with credits so array results are never dropped on FIFO full. Signals job completion after the array drains.

---
 rtl/syst_feed_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/syst_feed_ctrl.sv
// rtl/syst_feed_ctrl.sv - systolic array feed sequencer with result-FIFO credit tracking
// Optional credit-stall counter compiled in with SYST_FEED_CTRL_PERF_EN.
module syst_feed_ctrl #(
    parameter int WORD      = 32,
    parameter int LEN_W     = 8,
    parameter int DEPTH     = 16,
    parameter int DRAIN_CYC = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [LEN_W-1:0]             len_i,
    output logic                         busy_o,
    output logic                         done_o,
    input  logic [WORD-1:0]              s_data_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    output logic [WORD-1:0]              data_o,
    output logic                         valid_o,
    output logic                         valid_raw_1_o,
    output logic                         valid_raw_2_o,
    output logic                         valid_raw_3_o,
    output logic                         valid_raw_4_o,
    input  logic                         res_pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   credit_o,
    output logic [31:0]                  stall_cnt_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DW-1:0]     drain_q;
    logic [CW-1:0]     credit_q, credit_d;
    logic [WORD-1:0]   data_q;
    logic              valid_q;
    logic [2:0]        skew_q;
    logic              busy_q, done_q;
    logic              hs, pop_ok;

    assign s_ready_o = (state_q == ST_LOAD) && (credit_q < CW'(DEPTH));
    assign hs        = s_valid_i && s_ready_o;
    // A pop with no credit outstanding cannot correspond to a real FIFO entry.
    assign pop_ok    = res_pop_i && (credit_q != '0);

    always_comb begin
        credit_d = credit_q;
        if (hs && !pop_ok) begin
            credit_d = credit_q + CW'(1);
        end else if (!hs && pop_ok) begin
            credit_d = credit_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            state_q <= ST_LOAD;
                            rem_q   <= len_i;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= ST_DRAIN;
                            drain_q <= DW'(DRAIN_CYC);
                        end
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q - DW'(1);
                    if (drain_q <= DW'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            skew_q   <= '0;
            credit_q <= '0;
        end else begin
            valid_q  <= hs;
            if (hs) begin
                data_q <= s_data_i;
            end
            skew_q   <= {skew_q[1:0], valid_q};
            credit_q <= credit_d;
        end
    end

`ifdef SYST_FEED_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            stall_q <= '0;
        end else if (state_q == ST_LOAD && s_valid_i && credit_q == CW'(DEPTH) && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign valid_raw_1_o = valid_q;
    assign valid_raw_2_o = skew_q[0];
    assign valid_raw_3_o = skew_q[1];
    assign valid_raw_4_o = skew_q[2];
    assign credit_o      = credit_q;
endmodule
